// File: rtl/lab3_1_preimage_gen.sv
// Preimage generator for the lab3 5-input classifier.
// Walks x = 0..31 in ascending order and streams every x whose class
// {res,x_state} equals the class latched at start.
//
// Handshake: x_out is offered while x_valid=1 and is accepted on any rising
// edge where x_valid & x_ready are both high; while x_valid=1 and x_ready=0,
// x_out and x_valid stay frozen; x_valid never drops without an acceptance.
module lab3_1_preimage_gen #(
  parameter int N  = 5,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cls,
  output logic          busy,
  output logic [N-1:0]  x_out,
  output logic          x_valid,
  input  logic          x_ready,
  output logic          done,
  output logic [CW-1:0] count,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Classifier truth table split into its two output bits, bit i = input i.
  // res=1 marks the ON set, x_state=1 marks the don't-care set; no input has
  // both, so class 11 has no members.
  localparam logic [31:0] RES_MASK    = 32'h6538_7B27;
  localparam logic [31:0] XSTATE_MASK = 32'h1081_0040;

  logic [1:0]   state;
  logic [N-1:0] idx;
  logic [1:0]   cls_q;
  logic [1:0]   idx_class;
  logic         match;
  logic         last_idx;

  // Table lookup for the index currently being examined.
  always_comb begin
    idx_class = {RES_MASK[idx], XSTATE_MASK[idx]};
    match     = (idx_class == cls_q);
    last_idx  = (idx == {N{1'b1}});
  end

  // Status outputs decode directly from the FSM state.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    dbg_state = state;
  end

  // Enumeration FSM: scan one index per cycle, park in EMIT until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cls_q   <= 2'b00;
      x_out   <= '0;
      x_valid <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cls_q <= cls;
            idx   <= '0;
            count <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            x_out   <= idx;
            x_valid <= 1'b1;
            state   <= EMIT;
          end else if (last_idx) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        EMIT: begin
          if (x_ready) begin
            count   <= count + 1'b1;
            x_valid <= 1'b0;
            if (last_idx) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_1_preimage_gen.sv
// Bench for lab3_1_preimage_gen: member lists of each class drive a
// reference queue; a negedge monitor checks every accepted x, hold behaviour,
// busy, and the done cycle/count against it.
module tb_lab3_1_preimage_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] cls;
  logic       busy;
  logic [4:0] x_out;
  logic       x_valid;
  logic       x_ready;
  logic       done;
  logic [5:0] count;
  logic [1:0] dbg_state;

  lab3_1_preimage_gen #(.N(5), .CW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cls       (cls),
    .busy      (busy),
    .x_out     (x_out),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .done      (done),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int on_list[17] = '{0, 1, 2, 5, 8, 9, 11, 12, 13, 14, 19, 20, 21, 24, 26, 29, 30};
  int dc_list[4]  = '{6, 16, 23, 28};

  function automatic logic [1:0] ref_class(input int x);
    logic [1:0] c;
    c = 2'b00;
    foreach (on_list[i]) if (on_list[i] == x) c = 2'b10;
    foreach (dc_list[i]) if (dc_list[i] == x) c = 2'b01;
    return c;
  endfunction

  logic [4:0] exp_q[$];
  int         exp_count;

  task automatic build_expected(input logic [1:0] c);
    exp_q.delete();
    for (int x = 0; x < 32; x++) begin
      if (ref_class(x) == c) exp_q.push_back(5'(x));
    end
    exp_count = exp_q.size();
  endtask

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit         run_active = 0;
  bit         done_seen  = 0;
  int         cyc        = 0;
  int         done_cyc   = 0;
  int         valid_cycles = 0;
  bit         prev_valid = 0;
  bit         prev_ready = 0;
  logic [4:0] prev_x     = '0;
  int         ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  // ---------------- ready driver ----------------
  initial begin
    x_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       x_ready = 1'($urandom_range(0, 1));
        2:       x_ready = 1'b0;
        default: x_ready = 1'b1;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (run_active) begin
      cyc++;
      check("busy_in_run", busy, 1);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", x_valid, 1);
        check("hold_x", x_out, prev_x);
      end
      if (x_valid) valid_cycles++;
      if (x_valid && x_ready) begin
        check("member_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("x_out", x_out, exp_q.pop_front());
      end
      if (done) begin
        check("done_cycle_rule", cyc, 33 + valid_cycles);
        check("members_left", exp_q.size(), 0);
        check("count_at_done", count, exp_count);
        check("x_valid_at_done", x_valid, 0);
        done_cyc   = cyc;
        done_seen  = 1;
        run_active = 0;
      end
      prev_valid = x_valid;
      prev_ready = x_ready;
      prev_x     = x_out;
    end else begin
      check("done_outside_run", done, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input logic [1:0] c, input int rmode, input int exp_done, input bit inject);
    build_expected(c);
    ready_mode = rmode;
    @(posedge clk);
    #1;
    cls   = c;
    start = 1'b1;
    @(posedge clk);
    cyc          = 0;
    valid_cycles = 0;
    prev_valid   = 0;
    prev_ready   = 0;
    done_seen    = 0;
    run_active   = 1;
    #1;
    start = 1'b0;
    cls   = 2'($urandom_range(0, 3));
    for (int i = 0; i < 400 && !done_seen; i++) begin
      @(posedge clk);
      #1;
      if (inject && i == 10) begin
        start = 1'b1;
        cls   = 2'b00;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", done_seen, 1);
    run_active = 0;
    if (done_seen && exp_done != 0) check("done_cycle_literal", done_cyc, exp_done);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("count_held", count, exp_count);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cls   = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_x_valid", x_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // Pin the model with hand-derived facts.
    build_expected(2'b10);
    check("model_on_size", exp_q.size(), 17);
    check("model_on_last", exp_q[16], 30);
    build_expected(2'b01);
    check("model_dc_size", exp_q.size(), 4);
    check("model_dc_first", exp_q[0], 6);
    build_expected(2'b00);
    check("model_off_size", exp_q.size(), 11);
    check("model_off_last", exp_q[10], 31);
    build_expected(2'b11);
    check("model_11_size", exp_q.size(), 0);

    // T1: ON class, always ready.
    run(2'b10, 0, 50, 0);
    check("t1_count", count, 17);
    // T2: DC class, random backpressure.
    run(2'b01, 1, 0, 0);
    check("t2_count", count, 4);
    // T3: OFF class ending on index 31.
    run(2'b00, 0, 44, 0);
    check("t3_count", count, 11);
    // T4: empty class.
    run(2'b11, 0, 33, 0);
    check("t4_count", count, 0);
    // T5: stray start during a run is ignored.
    run(2'b10, 0, 50, 1);
    check("t5_count", count, 17);

    // T6: reset while parked in EMIT.
    ready_mode = 2;
    @(posedge clk);
    #1;
    cls   = 2'b01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !x_valid; i++) @(negedge clk);
    check("t6_valid_before_rst", x_valid, 1);
    check("t6_x_before_rst", x_out, 6);
    rst = 1'b1;
    #1;
    check("t6_rst_x_valid", x_valid, 0);
    check("t6_rst_x_out", x_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_state", dbg_state, 0);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_done", done, 0);
    end
    rst = 1'b0;
    run(2'b01, 1, 0, 0);
    check("t6_fresh_count", count, 4);

    // A few extra random runs.
    repeat (4) run(2'($urandom_range(0, 3)), 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
